proc_controller: RTL and testbench

Control FSM for the single-cycle-datapath processor: fetch, decode and execute of 16-bit instructions. Drives the program counter, instruction register, data memory, register file and the 3-bit ALU result-mux select that feeds the ALU's 8-to-1 output mux. Sits directly upstream of the ALU select path and the register-file write-back mux. Purely Moore: every output is a function of the current state and the held instruction.

---
 rtl/proc_controller_if.sv | 31 +++
 rtl/proc_controller.sv | 129 ++++++++++++
 tb/tb_proc_controller.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/proc_controller_if.sv
// Control bundle between the processor control FSM and the datapath.
// The controller (master) receives the held instruction and drives every
// datapath control line; the datapath (slave) sees the opposite directions.
interface proc_controller_if;
  logic [15:0] IR;
  logic        PC_clr;
  logic        PC_up;
  logic        IR_ld;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic        RF_s;
  logic [3:0]  RF_W_addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  ALU_s;
  logic        Halted;
  logic [3:0]  State;

  modport master (
    input  IR,
    output PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, ALU_s, Halted, State
  );

  modport slave (
    output IR,
    input  PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, ALU_s, Halted, State
  );
endinterface

// File: rtl/proc_controller.sv
// Fetch/decode/execute control FSM for the single-cycle-datapath processor.
// Moore machine: every output depends only on the current state and the
// held instruction register, so an asynchronous reset immediately drops any
// pending write strobe.
module proc_controller (
  input  logic               Clock,
  input  logic               Resetn,
  proc_controller_if.master  bus
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_e;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  localparam logic [2:0] ALU_ZERO = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  state_e     state_q, state_d;
  logic [3:0] opcode;

  assign opcode = bus.IR[15:12];

  // State register; reset forces INIT without waiting for a clock edge.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_INIT;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples its pre-edge inputs, independent of statement order.
      state_q <= state_d;
    end
  end

  // Next-state logic; unused encodings 10-15 fall back to INIT.
  always_comb begin
    // NOTE: a default is assigned before the case so every path drives
    // state_d and no latch is inferred.
    state_d = S_INIT;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_NOOP;  // NOOP and every unassigned opcode
        endcase
      end
      S_NOOP:   state_d = S_FETCH;
      S_LOAD_A: state_d = S_LOAD_B;  // covers the synchronous memory read
      S_LOAD_B: state_d = S_FETCH;
      S_STORE:  state_d = S_FETCH;
      S_ADD:    state_d = S_FETCH;
      S_SUB:    state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;    // only reset leaves HALT
      default:  state_d = S_INIT;
    endcase
  end

  // Moore output decode from the current state and instruction fields.
  always_comb begin
    bus.PC_clr     = 1'b0;
    bus.PC_up      = 1'b0;
    bus.IR_ld      = 1'b0;
    bus.D_addr     = 8'h00;
    bus.D_wr       = 1'b0;
    bus.RF_s       = 1'b0;
    bus.RF_W_addr  = 4'h0;
    bus.RF_W_en    = 1'b0;
    bus.RF_Ra_addr = 4'h0;
    bus.RF_Rb_addr = 4'h0;
    bus.ALU_s      = ALU_ZERO;
    bus.Halted     = 1'b0;
    bus.State      = state_q;
    case (state_q)
      S_INIT: bus.PC_clr = 1'b1;
      S_FETCH: begin
        bus.IR_ld = 1'b1;
        bus.PC_up = 1'b1;
      end
      S_LOAD_A: begin
        bus.D_addr    = bus.IR[11:4];
        bus.RF_s      = 1'b1;
        bus.RF_W_addr = bus.IR[3:0];
      end
      S_LOAD_B: begin
        bus.D_addr    = bus.IR[11:4];
        bus.RF_s      = 1'b1;
        bus.RF_W_addr = bus.IR[3:0];
        bus.RF_W_en   = 1'b1;
      end
      S_STORE: begin
        bus.RF_Ra_addr = bus.IR[11:8];
        bus.D_addr     = bus.IR[7:0];
        bus.D_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        bus.RF_Ra_addr = bus.IR[11:8];
        bus.RF_Rb_addr = bus.IR[7:4];
        bus.RF_W_addr  = bus.IR[3:0];
        bus.RF_W_en    = 1'b1;
        bus.ALU_s      = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
      end
      S_HALT: bus.Halted = 1'b1;
      default: ;  // DECODE, NOOP and illegal codes keep the all-zero defaults
    endcase
  end

endmodule

// File: tb/tb_proc_controller.sv
// Scoreboard bench for proc_controller: expected per-cycle output snapshots
// are pushed when an instruction is issued and compared cycle by cycle.
module tb_proc_controller;

  logic Clock;
  logic Resetn;

  proc_controller_if bus ();

  proc_controller dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_clr;
    logic       pc_up;
    logic       ir_ld;
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic [3:0] rf_w_addr;
    logic       rf_w_en;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu_s;
    logic       halted;
  } snap_t;

  snap_t sb_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic snap_t sample();
    snap_t s;
    s.state     = bus.State;
    s.pc_clr    = bus.PC_clr;
    s.pc_up     = bus.PC_up;
    s.ir_ld     = bus.IR_ld;
    s.d_addr    = bus.D_addr;
    s.d_wr      = bus.D_wr;
    s.rf_s      = bus.RF_s;
    s.rf_w_addr = bus.RF_W_addr;
    s.rf_w_en   = bus.RF_W_en;
    s.ra        = bus.RF_Ra_addr;
    s.rb        = bus.RF_Rb_addr;
    s.alu_s     = bus.ALU_s;
    s.halted    = bus.Halted;
    return s;
  endfunction

  function automatic snap_t blank(input logic [3:0] st);
    snap_t s;
    s       = '0;
    s.state = st;
    return s;
  endfunction

  // Reference sequence of output snapshots for one instruction, from FETCH.
  task automatic push_expected(input logic [15:0] ir, input int halt_cycles);
    snap_t s;
    s = blank(4'd1); s.pc_up = 1'b1; s.ir_ld = 1'b1;
    sb_q.push_back(s);
    sb_q.push_back(blank(4'd2));
    case (ir[15:12])
      4'b0001: begin
        s = blank(4'd6); s.ra = ir[11:8]; s.d_addr = ir[7:0]; s.d_wr = 1'b1;
        sb_q.push_back(s);
      end
      4'b0010: begin
        s = blank(4'd4); s.d_addr = ir[11:4]; s.rf_s = 1'b1;
        s.rf_w_addr = ir[3:0];
        sb_q.push_back(s);
        s.state = 4'd5; s.rf_w_en = 1'b1;
        sb_q.push_back(s);
      end
      4'b0011, 4'b0100: begin
        s = blank((ir[15:12] == 4'b0011) ? 4'd7 : 4'd8);
        s.ra = ir[11:8]; s.rb = ir[7:4]; s.rf_w_addr = ir[3:0];
        s.rf_w_en = 1'b1;
        s.alu_s = (ir[15:12] == 4'b0011) ? 3'b001 : 3'b010;
        sb_q.push_back(s);
      end
      4'b0101: begin
        s = blank(4'd9); s.halted = 1'b1;
        for (int i = 0; i < halt_cycles; i++) sb_q.push_back(s);
      end
      default: sb_q.push_back(blank(4'd3));
    endcase
  endtask

  function automatic snap_t init_snap();
    snap_t s;
    s = blank(4'd0);
    s.pc_clr = 1'b1;
    return s;
  endfunction

  // Issue one instruction starting from the cycle before FETCH; optionally
  // abort it with an asynchronous reset in the middle of LOAD_B.
  task automatic run_instr(input logic [15:0] ir, input bit abort_lb);
    snap_t      exp, got;
    int         n_wen, n_dwr, n_up, n_ld;
    logic [3:0] op;
    n_wen = 0; n_dwr = 0; n_up = 0; n_ld = 0;
    op = ir[15:12];
    push_expected(ir, 20);
    while (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      @(negedge Clock);
      if (exp.state == 4'd1) bus.IR = 16'($urandom);  // ignored in FETCH
      #1;
      got = sample();
      check($sformatf("ir=%h st=%0d", ir, exp.state), 64'(got), 64'(exp));
      n_wen += int'(got.rf_w_en);
      n_dwr += int'(got.d_wr);
      n_up  += int'(got.pc_up);
      n_ld  += int'(got.ir_ld);
      if (exp.state == 4'd1) bus.IR = ir;
      if (abort_lb && exp.state == 4'd5) begin
        Resetn = 1'b0;
        #1;
        check("abort_async", 64'(sample()), 64'(init_snap()));
        sb_q.delete();
        @(posedge Clock);
        @(negedge Clock);
        check("abort_held", 64'(sample()), 64'(init_snap()));
        Resetn = 1'b1;
        #1;
        check("abort_release", 64'(sample()), 64'(init_snap()));
        return;
      end
    end
    check($sformatf("ir=%h n_wen", ir), 64'(n_wen),
          64'((op == 4'b0010 || op == 4'b0011 || op == 4'b0100) ? 1 : 0));
    check($sformatf("ir=%h n_dwr", ir), 64'(n_dwr), 64'((op == 4'b0001) ? 1 : 0));
    check($sformatf("ir=%h n_up", ir), 64'(n_up), 64'(1));
    check($sformatf("ir=%h n_ld", ir), 64'(n_ld), 64'(1));
  endtask

  // Reset pulse issued at a falling edge; state must hit INIT at once.
  task automatic reset_pulse(input string tag);
    Resetn = 1'b0;
    #1;
    check({tag, "_async"}, 64'(sample()), 64'(init_snap()));
    @(posedge Clock);
    @(negedge Clock);
    check({tag, "_held"}, 64'(sample()), 64'(init_snap()));
    Resetn = 1'b1;
    #1;
    check({tag, "_release"}, 64'(sample()), 64'(init_snap()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ir;
    Resetn = 1'b0;
    bus.IR = 16'h0000;
    #1;
    check("reset_async", 64'(sample()), 64'(init_snap()));
    @(posedge Clock);
    @(posedge Clock);
    @(negedge Clock);
    check("reset_held", 64'(sample()), 64'(init_snap()));
    Resetn = 1'b1;
    #1;
    check("reset_release", 64'(sample()), 64'(init_snap()));

    run_instr(16'h3125, 1'b0);  // ADD
    run_instr(16'h4ABC, 1'b0);  // SUB
    run_instr(16'h137F, 1'b0);  // STORE
    run_instr(16'h2A43, 1'b0);  // LOAD
    run_instr(16'hF000, 1'b0);  // illegal opcode behaves as NOOP
    run_instr(16'h0000, 1'b0);  // NOOP
    run_instr(16'h5000, 1'b0);  // HALT, held 20 cycles
    reset_pulse("halt_reset");

    for (int i = 0; i < 12; i++) begin
      ir = 16'($urandom);
      if (ir[15:12] == 4'b0101) ir[15:12] = 4'b0010;
      run_instr(ir, 1'b0);
    end

    run_instr(16'h2A43, 1'b1);  // LOAD aborted in LOAD_B
    run_instr(16'h3FE1, 1'b0);  // clean restart after the abort

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
